// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared fetch FSM states, fetch-entry type and reset PC default
package if_fetch_ctrl_pkg;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: 2-entry fetch buffer between imem responses and decode
// Ports: clk/rst_n (async active-low), push/din enqueue, pop dequeue (head on dout),
//        clear empties the buffer, full/empty/cnt report occupancy.
module if_fetch_fifo
    import if_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   cnt
);
    fetch_entry_t mem [2];
    logic wp, rp, wr, rd;
    assign rd    = pop && !empty;
    // a push into a full buffer is accepted when the head leaves in the same cycle
    assign wr    = push && (!full || rd);
    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign dout  = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else if (clear) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (rd) rp <= ~rp;
            cnt <= cnt + 2'(wr) - 2'(rd);
        end
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction fetch controller with redirect, kill and 2-entry fetch buffer
// Ports: i_clk, i_rst_n (async active-low); i_ex_* jump/branch redirects;
//        o_imem_req/o_imem_addr, i_imem_gnt, i_imem_rvalid/i_imem_rdata imem side;
//        o_id_valid/o_id_instr/o_id_pc, i_id_ready decode side; o_flush, o_misaligned.
// Macro IF_RVC_EN: allows redirect targets aligned to 2 bytes.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MAX_OUTST = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_jump_taken,
    input  logic        i_ex_branch_taken,
    input  logic [63:0] i_ex_jump_target,
    input  logic [63:0] i_ex_branch_target,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_id_valid,
    output logic [31:0] o_id_instr,
    output logic [63:0] o_id_pc,
    input  logic        i_id_ready,
    output logic        o_flush,
    output logic        o_misaligned
);
    localparam logic [7:0] MAX_O = 8'(MAX_OUTST);
    fetch_state_t state, state_n;
    logic [63:0]  pc, pc_n, rsp_pc, rsp_pc_n, tgt;
    logic [7:0]   out_cnt, out_n, kill_cnt, kill_n;
    logic [1:0]   fifo_cnt;
    logic         rd, mis, rv_eff, push, pop, full, empty, mis_q, mis_n;
    fetch_entry_t head, din;
    assign tgt = {i_ex_jump_taken ? i_ex_jump_target[63:1] : i_ex_branch_target[63:1], 1'b0};
`ifdef IF_RVC_EN
    assign mis = 1'b0;
`else
    assign mis = tgt[1];
`endif
    assign rd     = (i_ex_jump_taken || i_ex_branch_taken) && state == S_RUN;
    assign rv_eff = i_imem_rvalid && out_cnt != 8'd0;
    assign push   = rv_eff && kill_cnt == 8'd0 && !rd;
    assign pop    = o_id_valid && i_id_ready;
    // responses are in order, so the pc of the next kept response is tracked, not stored per request
    assign din    = '{pc: rsp_pc, instr: i_imem_rdata};
    always_comb begin
        // killed requests do not throttle, so fetch at a redirect target starts immediately
        o_imem_req = state == S_RUN && !rd && (out_cnt - kill_cnt + 8'(fifo_cnt)) < MAX_O;
        state_n    = (rd && mis) ? S_HALT : (state == S_BOOT) ? S_RUN : state;
        pc_n       = rd ? tgt : (o_imem_req && i_imem_gnt) ? pc + 64'd4 : pc;
        rsp_pc_n   = rd ? tgt : push ? rsp_pc + 64'd4 : rsp_pc;
        out_n      = out_cnt + 8'(o_imem_req && i_imem_gnt) - 8'(rv_eff);
        kill_n     = rd ? out_cnt - 8'(rv_eff) : kill_cnt - 8'(rv_eff && kill_cnt != 8'd0);
        mis_n      = mis_q || (rd && mis);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= 8'd0;
            kill_cnt <= 8'd0;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            rsp_pc   <= rsp_pc_n;
            out_cnt  <= out_n;
            kill_cnt <= kill_n;
            mis_q    <= mis_n;
        end
    end
    if_fetch_fifo u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .clear (rd),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .cnt   (fifo_cnt)
    );
    assign o_imem_addr  = pc;
    assign o_flush      = rd;
    assign o_id_valid   = !empty && !rd;
    assign o_id_instr   = head.instr;
    assign o_id_pc      = head.pc;
    assign o_misaligned = mis_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: self-checking bench for if_fetch_ctrl with an in-order imem model
module tb_if_fetch_ctrl;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_ex_jump_taken, i_ex_branch_taken;
    logic [63:0] i_ex_jump_target, i_ex_branch_target;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_id_valid;
    logic [31:0] o_id_instr;
    logic [63:0] o_id_pc;
    logic        i_id_ready, o_flush, o_misaligned;

    if_fetch_ctrl dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_ex_jump_taken    (i_ex_jump_taken),
        .i_ex_branch_taken  (i_ex_branch_taken),
        .i_ex_jump_target   (i_ex_jump_target),
        .i_ex_branch_target (i_ex_branch_target),
        .o_imem_req         (o_imem_req),
        .o_imem_addr        (o_imem_addr),
        .i_imem_gnt         (i_imem_gnt),
        .i_imem_rvalid      (i_imem_rvalid),
        .i_imem_rdata       (i_imem_rdata),
        .o_id_valid         (o_id_valid),
        .o_id_instr         (o_id_instr),
        .o_id_pc            (o_id_pc),
        .i_id_ready         (i_id_ready),
        .o_flush            (o_flush),
        .o_misaligned       (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0, errors = 0, delivered = 0, dead = 0;
    int unsigned gnt_pct, rv_pct, rdy_pct;
    logic [63:0] pend [$];
    logic [63:0] exp_fetch, exp_id;
    bit          halted = 1'b0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_chk();
        chk("rst_req", o_imem_req, 0);
        chk("rst_addr", o_imem_addr, RST_PC);
        chk("rst_id_valid", o_id_valid, 0);
        chk("rst_flush", o_flush, 0);
        chk("rst_mis", o_misaligned, 0);
        chk("rst_instr", o_id_instr, 0);
        chk("rst_id_pc", o_id_pc, 0);
    endtask

    // One clock: drive at negedge, observe 1ns later, advance the reference model.
    task automatic cycle(input bit jmp, input bit br, input logic [63:0] jt, input logic [63:0] bt);
        logic [63:0] t;
        @(negedge i_clk);
        i_imem_gnt         = $urandom_range(99) < gnt_pct;
        i_imem_rvalid      = pend.size() > 0 && $urandom_range(99) < rv_pct;
        i_imem_rdata       = i_imem_rvalid ? instr_of(pend[0]) : 32'h0;
        i_id_ready         = $urandom_range(99) < rdy_pct;
        i_ex_jump_taken    = jmp;
        i_ex_branch_taken  = br;
        i_ex_jump_target   = jt;
        i_ex_branch_target = bt;
        #1;
        if (i_imem_rvalid) begin
            void'(pend.pop_front());
            if (dead > 0) dead--;
        end
        if (o_imem_req) begin
            chk("req_addr", o_imem_addr, exp_fetch);
            if (i_imem_gnt) begin
                pend.push_back(exp_fetch);
                exp_fetch += 64'd4;
            end
        end
        if (o_id_valid && i_id_ready) begin
            chk("id_pc", o_id_pc, exp_id);
            chk("id_instr", {32'h0, o_id_instr}, {32'h0, instr_of(exp_id)});
            exp_id += 64'd4;
            delivered++;
        end
        if (jmp || br) begin
            t = jmp ? jt : bt;
            t[0] = 1'b0;
            chk("flush", o_flush, 1);
            chk("flush_id_valid", o_id_valid, 0);
            chk("flush_req", o_imem_req, 0);
            exp_fetch = t;
            exp_id = t;
            dead = pend.size();
`ifndef IF_RVC_EN
            if (t[1]) halted = 1'b1;
`endif
        end else begin
            chk("no_flush", o_flush, 0);
        end
        if (halted) chk("halt_req", o_imem_req, 0);
        chk("live_bound", (pend.size() - dead) <= 2, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        logic [63:0] jt, bt;
        bit          j, b;
        i_rst_n = 1'b0;
        {i_ex_jump_taken, i_ex_branch_taken, i_imem_gnt, i_imem_rvalid, i_id_ready} = '0;
        i_ex_jump_target = '0;
        i_ex_branch_target = '0;
        i_imem_rdata = '0;
        exp_fetch = RST_PC;
        exp_id = RST_PC;
        repeat (2) @(negedge i_clk);
        #1 reset_chk();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("boot_req", o_imem_req, 0);

        // sequential fetch with immediate grant and one-cycle response
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
        delivered = 0;
        for (int i = 0; i < 20 && delivered < 3; i++) idle(1);
        chk("first_three", delivered >= 3, 1);

        // decode stalled: buffer fills, fetch stops, nothing lost on resume
        rdy_pct = 0;
        idle(10);
        chk("stall_valid", o_id_valid, 1);
        chk("stall_req", o_imem_req, 0);
        chk("stall_drained", pend.size(), 0);
        rdy_pct = 100;
        delivered = 0;
        idle(10);
        chk("stall_resume", delivered >= 2, 1);

        // random handshakes, no redirects
        gnt_pct = 60; rv_pct = 50; rdy_pct = 70;
        repeat (300) idle(1);

        // jump with two requests outstanding
        gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
        for (int i = 0; i < 20 && pend.size() < 2; i++) idle(1);
        chk("two_outst", pend.size(), 2);
        cycle(1'b1, 1'b0, 64'h8000_1000, 64'h0);
        idle(1);
        chk("jump_req", o_imem_req, 1);
        chk("jump_addr", o_imem_addr, 64'h8000_1000);
        rv_pct = 100;
        delivered = 0;
        for (int i = 0; i < 20 && delivered < 1; i++) idle(1);
        chk("jump_delivered", delivered >= 1, 1);

        // jump wins over branch in the same cycle
        cycle(1'b1, 1'b1, 64'h100, 64'h200);
        idle(1);
        chk("prio_req", o_imem_req, 1);
        chk("prio_addr", o_imem_addr, 64'h100);
        idle(10);

        // random traffic with random redirects (bit0 may be set, bit1 clear)
        gnt_pct = 70; rv_pct = 60; rdy_pct = 70;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 5) begin
                jt = {$urandom, $urandom} & ~64'h2;
                bt = {$urandom, $urandom} & ~64'h2;
                j = 1'($urandom_range(1));
                b = j ? 1'($urandom_range(1)) : 1'b1;
                cycle(j, b, jt, bt);
            end else begin
                idle(1);
            end
        end

        // reset while the fetch buffer is full
        gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
        idle(10);
        chk("pre_rst_valid", o_id_valid, 1);
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 reset_chk();
        pend.delete();
        dead = 0;
        exp_fetch = RST_PC;
        exp_id = RST_PC;
        rdy_pct = 100;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("post_rst_boot", o_imem_req, 0);
        idle(1);
        chk("post_rst_req", o_imem_req, 1);
        chk("post_rst_addr", o_imem_addr, RST_PC);
        idle(5);

        // 2-byte aligned branch target
        cycle(1'b0, 1'b1, 64'h0, 64'h8000_0102);
        idle(1);
`ifdef IF_RVC_EN
        chk("rvc_req", o_imem_req, 1);
        chk("rvc_addr", o_imem_addr, 64'h8000_0102);
        idle(10);
        chk("rvc_mis", o_misaligned, 0);
`else
        chk("mis_flag", o_misaligned, 1);
        idle(20);
        chk("mis_sticky", o_misaligned, 1);
        chk("halt_no_req", o_imem_req, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
